// File: rtl/logic_gate_acc.sv
// Registered multi-lane bitwise reducer that folds a multi-beat packet into one result.
// Optional out_parity port is built when LOGIC_GATE_ACC_PARITY_EN is defined.
module logic_gate_acc #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CNT_W-1:0]        out_count
`ifdef LOGIC_GATE_ACC_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  typedef enum logic [1:0] {B_AND, B_OR, B_XOR, B_PASS} base_t;

  state_t             state, state_next;
  base_t              base;
  logic [2:0]         op_q, eff_op;
  logic               invert;
  logic               beat_acc;
  logic [WIDTH-1:0]   acc, lane_fold, combined, result;
  logic [CNT_W-1:0]   cnt, cnt_next;

  assign beat_acc = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE, ACC: begin
        in_ready = 1'b1;
        if (in_valid) state_next = in_last ? HOLD : ACC;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The op is taken live on the first beat and from the latched copy afterwards.
  always_comb begin
    eff_op = (state == IDLE) ? in_op : op_q;
    unique case (eff_op)
      3'b001, 3'b100: base = B_OR;
      3'b010, 3'b101: base = B_XOR;
      3'b110:         base = B_PASS;
      default:        base = B_AND;
    endcase
    invert = (eff_op == 3'b011) || (eff_op == 3'b100) || (eff_op == 3'b101);

    lane_fold = in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      unique case (base)
        B_AND:   lane_fold = lane_fold & in_data[k*WIDTH +: WIDTH];
        B_OR:    lane_fold = lane_fold | in_data[k*WIDTH +: WIDTH];
        B_XOR:   lane_fold = lane_fold ^ in_data[k*WIDTH +: WIDTH];
        default: lane_fold = lane_fold;
      endcase
    end

    if (state == IDLE) begin
      combined = lane_fold;
    end else begin
      unique case (base)
        B_AND:   combined = acc & lane_fold;
        B_OR:    combined = acc | lane_fold;
        B_XOR:   combined = acc ^ lane_fold;
        default: combined = lane_fold;
      endcase
    end
    // Inversion only touches the value published, never the running accumulator.
    result = invert ? ~combined : combined;

    if (state == IDLE)  cnt_next = CNT_W'(1);
    else if (cnt == '1) cnt_next = cnt;
    else                cnt_next = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      op_q       <= '0;
      out_data   <= '0;
      out_count  <= '0;
`ifdef LOGIC_GATE_ACC_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (beat_acc) begin
      acc <= combined;
      cnt <= cnt_next;
      if (state == IDLE) op_q <= in_op;
      if (in_last) begin
        out_data   <= result;
        out_count  <= cnt_next;
`ifdef LOGIC_GATE_ACC_PARITY_EN
        out_parity <= ^result;
`endif
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_acc.sv
// Randomized bench for logic_gate_acc with a packet-level reference model;
// a second instance with a 2-bit counter exercises count saturation.
module tb_logic_gate_acc;
  localparam int W  = 8;
  localparam int NI = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [NI*W-1:0] in_data = '0;
  logic [2:0]      in_op = '0;
  logic            in_last = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready, in_ready_s;
  logic            out_valid, out_valid_s;
  logic [W-1:0]    out_data, out_data_s;
  logic [7:0]      out_count;
  logic [1:0]      out_count_s;
`ifdef LOGIC_GATE_ACC_PARITY_EN
  logic            out_parity, out_parity_s;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [NI*W-1:0] pkt_q[$];

  always #5 clk = ~clk;

  logic_gate_acc #(.WIDTH(W), .NUM_IN(NI), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
`ifdef LOGIC_GATE_ACC_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  logic_gate_acc #(.WIDTH(W), .NUM_IN(NI), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_count(out_count_s)
`ifdef LOGIC_GATE_ACC_PARITY_EN
    , .out_parity(out_parity_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flatten every lane of every beat into one list and reduce it.
  function automatic logic [W-1:0] model_data(input logic [2:0] op);
    logic [W-1:0]    r;
    logic [W-1:0]    lane;
    logic [NI*W-1:0] b;
    if (op == 3'b110) begin
      b = pkt_q[pkt_q.size()-1];
      return b[W-1:0];
    end
    r = (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b101) ? '0 : '1;
    foreach (pkt_q[i]) begin
      for (int l = 0; l < NI; l++) begin
        b    = pkt_q[i] >> (l * W);
        lane = b[W-1:0];
        case (op)
          3'b001, 3'b100: r = r | lane;
          3'b010, 3'b101: r = r ^ lane;
          default:        r = r & lane;
        endcase
      end
    end
    if (op == 3'b011 || op == 3'b100 || op == 3'b101) r = ~r;
    return r;
  endfunction

  function automatic int unsigned sat(input int unsigned n, input int unsigned cw);
    int unsigned mx;
    mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic drive_packet(input logic [2:0] op, input logic [2:0] later_op,
                              input int unsigned max_gap);
    for (int i = 0; i < pkt_q.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = pkt_q[i];
      in_op    = (i == 0) ? op : later_op;
      in_last  = (i == pkt_q.size() - 1);
      for (int g = 0; !in_ready && g < 20; g++) @(negedge clk);
      if (!in_ready) check("in_ready_wait", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = NI*W'($urandom);
      in_op    = 3'($urandom);
      if (i != pkt_q.size() - 1) check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    end
  endtask

  // Called right after the last beat's accepting edge: result must already be up.
  task automatic collect(input logic [2:0] op, input int unsigned hold, input bit busy);
    logic [W-1:0] exp;
    int unsigned  n;
    exp = model_data(op);
    n   = pkt_q.size();
    check("out_valid", {31'b0, out_valid}, 32'd1);
    check("out_data", {24'b0, out_data}, {24'b0, exp});
    check("out_count", {24'b0, out_count}, sat(n, 8));
    check("sat_data", {24'b0, out_data_s}, {24'b0, exp});
    check("sat_count", {30'b0, out_count_s}, sat(n, 2));
    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
`ifdef LOGIC_GATE_ACC_PARITY_EN
    check("out_parity", {31'b0, out_parity}, {31'b0, ^exp});
    check("sat_parity", {31'b0, out_parity_s}, {31'b0, ^exp});
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = busy;
      in_data  = NI*W'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_data", {24'b0, out_data}, {24'b0, exp});
      check("stall_count", {24'b0, out_count}, sat(n, 8));
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", {31'b0, out_valid}, 32'd0);
    check("release_in_ready", {31'b0, in_ready}, 32'd1);
    check("release_in_ready_s", {31'b0, in_ready_s}, 32'd1);
  endtask

  initial begin
    logic [2:0] op;
    int unsigned nb;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {24'b0, out_data}, 32'd0);
    check("rst_out_count", {24'b0, out_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);

    pkt_q = '{{8'h3C, 8'hF0}};
    drive_packet(3'b000, 3'b000, 0);
    collect(3'b000, 0, 1'b0);
    check("and_const", {24'b0, model_data(3'b000)}, 32'h30);

    pkt_q = '{{8'h02, 8'h01}, {8'h08, 8'h04}, {8'h20, 8'h10}};
    drive_packet(3'b010, 3'b000, 0);
    collect(3'b010, 0, 1'b0);

    pkt_q = '{{8'h30, 8'h0F}};
    drive_packet(3'b100, 3'b000, 0);
    collect(3'b100, 5, 1'b1);

    // Partial OR packet wiped by an asynchronous reset pulse between edges.
    in_valid = 1'b1; in_op = 3'b001; in_last = 1'b0; in_data = {8'h55, 8'hAA};
    @(negedge clk);
    in_op = 3'b000; in_data = {8'h0F, 8'hF0};
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_out_data", {24'b0, out_data}, 32'd0);
    check("mrst_out_count", {24'b0, out_count}, 32'd0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst_no_result", {31'b0, out_valid}, 32'd0);
    end

    pkt_q = '{{8'hFF, 8'hFF}, {8'hFF, 8'hFF}, {8'hFF, 8'hFF}, {8'hFF, 8'hFF}, {8'hFF, 8'hFF}};
    drive_packet(3'b000, 3'b000, 0);
    collect(3'b000, 0, 1'b0);

    for (int p = 0; p < 60; p++) begin
      op = 3'($urandom);
      nb = $urandom_range(6, 1);
      pkt_q.delete();
      for (int b = 0; b < nb; b++) pkt_q.push_back(NI*W'($urandom));
      drive_packet(op, 3'($urandom), 2);
      collect(op, $urandom_range(3, 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
